result_capture_module: RTL

Terminal sink for the inference pipeline. Accepts classifier output words over an AXI-Stream slave port, stores up to DEPTH of them, and tracks a running signed argmax. The processor reads captured words, status and argmax over an AXI4-Lite slave port and re-arms the block with a control write. It is the read-back end of the path that starts at the pixel loader's AXI-Lite-in / AXI-Stream-out.

---
 rtl/result_capture_module.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/result_capture_module.sv
// ============================================================================
//  Module  : result_capture_module
//  Brief   : AXI-Stream result sink with running signed argmax, read back and
//            re-armed over an AXI4-Lite slave port.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_capture_module #(
    parameter int DEPTH = 10
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,

    input  logic [31:0] y_tdata,
    input  logic        y_tvalid,
    output logic        y_tready,
    input  logic        y_tlast,
    output logic        done,

    input  logic [11:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [11:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_DEPTH32 = 32'(DEPTH);
    localparam logic [8:0]  c_DEPTH9  = 9'(DEPTH);
    localparam logic [9:0]  c_CTRL_IDX = 10'h203;

    typedef enum logic [0:0] {
        ST_CAPTURE = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_tready;
    logic               w_tready_nxt;

    logic [31:0]        r_mem [DEPTH];
    logic [7:0]         r_count;
    logic [7:0]         r_argmax;
    logic signed [31:0] r_maxval;

    logic               r_awready;
    logic               r_bvalid;
    logic               r_arready;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [31:0]        w_rdata_nxt;

    logic               w_beat;
    logic               w_wr_hs;
    logic               w_rd_hs;
    logic               w_clear;
    logic [8:0]         w_count_inc;
    logic               w_unused_ok;

    assign w_beat      = y_tvalid & r_tready;
    assign w_wr_hs     = r_awready & s_axi_awvalid & s_axi_wvalid;
    assign w_rd_hs     = r_arready & s_axi_arvalid;
    assign w_clear     = w_wr_hs & (s_axi_awaddr[11:2] == c_CTRL_IDX) & s_axi_wdata[0];
    assign w_count_inc = {1'b0, r_count} + 9'd1;

    assign y_tready      = r_tready;
    assign done          = (r_state == ST_DONE);
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:1]};

    // ------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state  <= ST_CAPTURE;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= w_tready_nxt;
        end
    end

    // ready is registered from the next state so it falls on the same edge done rises
    always_comb begin
        w_state_nxt  = r_state;
        w_tready_nxt = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                if (!w_clear && w_beat && (y_tlast || (w_count_inc == c_DEPTH9)))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_clear)
                    w_state_nxt = ST_CAPTURE;
            end
            default: w_state_nxt = ST_CAPTURE;
        endcase
        w_tready_nxt = (w_state_nxt == ST_CAPTURE);
    end

    // ------------------------------------------------------------------
    // Result storage and running argmax; a clear discards a coincident beat
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count  <= '0;
            r_argmax <= '0;
            r_maxval <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count  <= '0;
            r_argmax <= '0;
            r_maxval <= '0;
        end else if (w_beat) begin
            r_mem[r_count[c_AW-1:0]] <= y_tdata;
            r_count                  <= w_count_inc[7:0];
            if ((r_count == 8'd0) || ($signed(y_tdata) > r_maxval)) begin
                r_argmax <= r_count;
                r_maxval <= $signed(y_tdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // AXI4-Lite write channel
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_awready;
            if (w_wr_hs)
                r_bvalid <= 1'b1;
            else if (r_bvalid && s_axi_bready)
                r_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // AXI4-Lite read channel
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_nxt = '0;
        if (!s_axi_araddr[11]) begin
            if (32'(s_axi_araddr[10:2]) < c_DEPTH32)
                w_rdata_nxt = r_mem[s_axi_araddr[c_AW+1:2]];
        end else begin
            case (s_axi_araddr[10:2])
                9'h000:  w_rdata_nxt = {16'h0000, r_count, 7'b0000000, done};
                9'h001:  w_rdata_nxt = {24'h000000, r_argmax};
                9'h002:  w_rdata_nxt = r_maxval;
                default: w_rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= s_axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata_nxt;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
